ysyx_25060170_pipe_stage: RTL and testbench

//  Parametrised elastic pipeline-stage register. Replaces the fixed single-entry
//  if/id, id/ex, ex/ls and ls/wb registers. Provides a valid/ready handshake,

---
 rtl/ysyx_25060170_pipe_stage.sv | 213 +++++++++++++++++++++
 tb/tb_ysyx_25060170_pipe_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060170_pipe_stage.sv
// ---------------------------------------------------------------------------
// ysyx_25060170_pipe_stage
//
// Elastic pipeline-stage register with a valid/ready handshake on each side
// and DEPTH entries of buffering. It sits between two core stages and carries
// an opaque payload bus, for example {pc, inst, ctl}.
//
// A payload pushed into an empty stage shows up on out_* exactly one cycle
// later; there is no empty-bypass path. While the stage is empty, after reset
// and after a flush, out_data shows RESET_VAL (typically a NOP encoding).
//
// Parameters
//   DATA_W     payload width in bits (>= 1)
//   DEPTH      number of buffer entries (>= 1, any value)
//   RESET_VAL  out_data value while the stage is empty
//
// Ports
//   clk        core clock
//   rst        synchronous active-high reset (takes priority over flush)
//   flush      drop every entry; a same-cycle push is discarded and no pop
//              is reported
//   in_valid   upstream offers a payload
//   in_ready   the stage accepts the payload this cycle
//   in_data    upstream payload (sampled only on an accepted push)
//   out_valid  the head entry is valid
//   out_ready  downstream takes the head entry
//   out_data   head payload, or RESET_VAL while empty
//   count      current occupancy, 0..DEPTH
//   stall_cnt  cycles with in_valid & !in_ready (saturating)
//   bubble_cnt cycles with out_ready & !out_valid (saturating)
//
// Build option
//   PIPE_STAGE_PERF_EN  When defined, stall_cnt and bubble_cnt are 32-bit
//                       saturating counters. They clear on rst and survive
//                       flush. When undefined, no counter logic is built and
//                       both ports are tied to zero. The port list is the
//                       same in both builds.
// ---------------------------------------------------------------------------
module ysyx_25060170_pipe_stage #(
  parameter int unsigned        DATA_W    = 64,
  parameter int unsigned        DEPTH     = 2,
  parameter logic [DATA_W-1:0]  RESET_VAL = {DATA_W{1'b0}},
  localparam int unsigned       CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
);

  // A single-entry stage still needs a one-bit pointer. The pointer simply
  // stays at zero in that case.
  localparam int unsigned     PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

  // -------------------------------------------------------------------------
  // Storage and state
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_next;

  logic not_empty;
  logic not_full;
  logic push;
  logic pop;

  // The pointers wrap explicitly at DEPTH-1, so DEPTH does not have to be a
  // power of two. Occupancy comes from count_reg. It is never derived from a
  // comparison of the two pointers.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  // in_ready looks at out_ready combinationally. A full stage can therefore
  // accept a new payload in the same cycle that its head leaves, which keeps
  // throughput at one payload per cycle even when DEPTH is 1.
  // flush masks both sides. As a result, push and pop are already false in
  // a flush cycle, and the state update only has to force the clear.
  always_comb begin
    not_empty = (count_reg != '0);
    not_full  = (count_reg != DEPTH_CNT);
    in_ready  = !flush && (not_full || out_ready);
    out_valid = !flush && not_empty;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // The head is read straight from the storage array. This gives exactly one
  // cycle of latency from push to visibility.
  always_comb begin
    if (not_empty) begin
      out_data = mem[rd_ptr_reg];
    end else begin
      out_data = RESET_VAL;
    end
  end

  assign count = count_reg;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;

    if (flush) begin
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else begin
      if (push) begin
        wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      // A simultaneous push and pop leaves the occupancy unchanged. This
      // applies when full and when holding a single entry.
      if (push && !pop) begin
        count_next = count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_next = count_reg - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
    end
  end

  // The storage itself is not reset. Entries are only observed while
  // count_reg says they are valid, and the empty value comes from RESET_VAL.
  // A full stage with out_ready low has push low, so the array is not
  // written in that case.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] stall_cnt_next;
  logic [31:0] bubble_cnt_reg;
  logic [31:0] bubble_cnt_next;

  // Both counters saturate instead of wrapping, so a long run never reports
  // a small value. Stall and bubble cycles caused by flush are included
  // because flush drops in_ready and out_valid.
  always_comb begin
    stall_cnt_next  = stall_cnt_reg;
    bubble_cnt_next = bubble_cnt_reg;
    if (in_valid && !in_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_next = stall_cnt_reg + 32'd1;
    end
    if (out_ready && !out_valid && (bubble_cnt_reg != 32'hFFFF_FFFF)) begin
      bubble_cnt_next = bubble_cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      stall_cnt_reg  <= stall_cnt_next;
      bubble_cnt_reg <= bubble_cnt_next;
    end
  end

  assign stall_cnt  = stall_cnt_reg;
  assign bubble_cnt = bubble_cnt_reg;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_25060170_pipe_stage.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_25060170_pipe_stage.
// Three instances (DEPTH = 2, 1 and 3) share one stimulus stream. Each
// instance is compared every cycle against a queue-based reference model of
// the stage. Directed phases run first, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_ysyx_25060170_pipe_stage;

  localparam int          DW  = 16;
  localparam logic [DW-1:0] RV = 16'h0013;
  localparam int          DEP [3] = '{2, 1, 3};

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;

  logic          ir_a, ir_b, ir_c;
  logic          ov_a, ov_b, ov_c;
  logic [DW-1:0] od_a, od_b, od_c;
  logic [1:0]    cnt_a;
  logic [0:0]    cnt_b;
  logic [1:0]    cnt_c;
  logic [31:0]   sc_a, sc_b, sc_c;
  logic [31:0]   bc_a, bc_b, bc_c;

  always #5 clk = ~clk;

  ysyx_25060170_pipe_stage #(.DATA_W(DW), .DEPTH(2), .RESET_VAL(RV)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
    .in_data(in_data), .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
    .count(cnt_a), .stall_cnt(sc_a), .bubble_cnt(bc_a));

  ysyx_25060170_pipe_stage #(.DATA_W(DW), .DEPTH(1), .RESET_VAL(RV)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_b),
    .in_data(in_data), .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
    .count(cnt_b), .stall_cnt(sc_b), .bubble_cnt(bc_b));

  ysyx_25060170_pipe_stage #(.DATA_W(DW), .DEPTH(3), .RESET_VAL(RV)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_c),
    .in_data(in_data), .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c),
    .count(cnt_c), .stall_cnt(sc_c), .bubble_cnt(bc_c));

  // Observed values gathered per instance index.
  logic          o_ir  [3];
  logic          o_ov  [3];
  logic [DW-1:0] o_od  [3];
  logic [1:0]    o_cnt [3];
  logic [31:0]   o_sc  [3];
  logic [31:0]   o_bc  [3];

  always_comb begin
    o_ir[0] = ir_a;  o_ir[1] = ir_b;  o_ir[2] = ir_c;
    o_ov[0] = ov_a;  o_ov[1] = ov_b;  o_ov[2] = ov_c;
    o_od[0] = od_a;  o_od[1] = od_b;  o_od[2] = od_c;
    o_cnt[0] = cnt_a; o_cnt[1] = {1'b0, cnt_b}; o_cnt[2] = cnt_c;
    o_sc[0] = sc_a;  o_sc[1] = sc_b;  o_sc[2] = sc_c;
    o_bc[0] = bc_a;  o_bc[1] = bc_b;  o_bc[2] = bc_c;
  end

  // Reference model: a queue of held payloads plus two performance tallies
  // per instance.
  logic [DW-1:0] q [3][$];
  logic [31:0]   stall_m  [3];
  logic [31:0]   bubble_m [3];
  bit            accepted_all;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit m_ready(input int i);
    return !flush && ((q[i].size() < DEP[i]) || out_ready);
  endfunction

  function automatic bit m_valid(input int i);
    return !flush && (q[i].size() != 0);
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      logic [DW-1:0] exp_od;
      logic [31:0]   exp_sc;
      logic [31:0]   exp_bc;
      exp_od = (q[i].size() != 0) ? q[i][0] : RV;
`ifdef PIPE_STAGE_PERF_EN
      exp_sc = stall_m[i];
      exp_bc = bubble_m[i];
`else
      exp_sc = 32'd0;
      exp_bc = 32'd0;
`endif
      chk($sformatf("d%0d.in_ready", DEP[i]),   64'(o_ir[i]),  64'(m_ready(i)));
      chk($sformatf("d%0d.out_valid", DEP[i]),  64'(o_ov[i]),  64'(m_valid(i)));
      chk($sformatf("d%0d.out_data", DEP[i]),   64'(o_od[i]),  64'(exp_od));
      chk($sformatf("d%0d.count", DEP[i]),      64'(o_cnt[i]), 64'(q[i].size()));
      chk($sformatf("d%0d.stall_cnt", DEP[i]),  64'(o_sc[i]),  64'(exp_sc));
      chk($sformatf("d%0d.bubble_cnt", DEP[i]), 64'(o_bc[i]),  64'(exp_bc));
    end
  endtask

  // Advance the model by one clock using the inputs applied for this cycle.
  task automatic update_model();
    accepted_all = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        q[i].delete();
        stall_m[i]  = 32'd0;
        bubble_m[i] = 32'd0;
      end else begin
        bit rdy;
        bit vld;
        rdy = m_ready(i);
        vld = m_valid(i);
        if (in_valid && !rdy) begin
          accepted_all = flush;
          if (stall_m[i] != 32'hFFFF_FFFF) stall_m[i]++;
        end
        if (out_ready && !vld && bubble_m[i] != 32'hFFFF_FFFF) bubble_m[i]++;
        if (flush) begin
          q[i].delete();
        end else begin
          if (vld && out_ready) begin
            if (i == 0) $display("t=%0t d2 pop data=%h", $time, q[i][0]);
            void'(q[i].pop_front());
          end
          if (in_valid && rdy) q[i].push_back(in_data);
        end
      end
    end
  endtask

  // Inputs change 1 time unit after a rising edge. Checks happen on the
  // falling edge. The model is then advanced and the next rising edge taken.
  task automatic cycle(input bit do_chk);
    #4;
    if (do_chk) check_all();
    update_model();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] next_val;
  logic [31:0]   exp_stall;
  logic [31:0]   exp_bubble;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    for (int i = 0; i < 3; i++) begin
      stall_m[i] = 0;
      bubble_m[i] = 0;
    end

    // T1: two reset cycles. The first check happens on the first cycle
    // after reset.
    cycle(0);
    cycle(0);
    rst = 1'b0;

    // T2: fill DEPTH=2 with 0x11 and 0x22 while out_ready is low, then drain.
    in_valid = 1'b1; in_data = 16'h0011; cycle(1);
    in_data = 16'h0022; cycle(1);
    in_valid = 1'b0; cycle(1);
    out_ready = 1'b1; cycle(1); cycle(1); cycle(1);

    // T3: full throughput with continuous valid and ready.
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = 16'h0040 + 16'(k);
      cycle(1);
    end
    in_valid = 1'b0; cycle(1); cycle(1);

    // T4: flush with a simultaneous push of 0x33.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'h0001; cycle(1);
    in_data = 16'h0002; cycle(1);
    flush = 1'b1; in_data = 16'h0033; cycle(1);
    flush = 1'b0; in_valid = 1'b0; cycle(1);
    out_ready = 1'b1; cycle(1); cycle(1);

    // T5: pointer wrap with out_ready toggling. A new value is offered only
    // once the DEPTH=3 instance has taken the previous one.
    next_val = 16'h0050;
    for (int k = 0; k < 24; k++) begin
      out_ready = (k % 2 == 0);
      in_valid  = (next_val < 16'h005A);
      in_data   = next_val;
      if (in_valid && m_ready(2)) next_val = next_val + 16'd1;
      cycle(1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle(1);

    // T6: performance counters after a fresh reset.
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cycle(1);
    rst = 1'b0; in_valid = 1'b1; in_data = 16'h0061;
    for (int k = 0; k < 7; k++) cycle(1);
`ifdef PIPE_STAGE_PERF_EN
    exp_stall = 32'd5;
    exp_bubble = 32'd4;
`else
    exp_stall = 32'd0;
    exp_bubble = 32'd0;
`endif
    chk("T6.d2.stall_cnt", 64'(sc_a), 64'(exp_stall));
    in_valid = 1'b0; flush = 1'b1; cycle(1);
    flush = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle(1);
    chk("T6.d2.bubble_cnt", 64'(bc_a), 64'(exp_bubble));
    chk("T6.d2.stall_hold", 64'(sc_a), 64'(exp_stall));

    // Randomized phase. A payload that is offered stays stable until every
    // instance has accepted it or a flush drops it.
    next_val = 16'h1000;
    accepted_all = 1'b1;
    for (int k = 0; k < 400; k++) begin
      flush     = ($urandom_range(0, 24) == 0);
      out_ready = $urandom_range(0, 2) != 0;
      if (!(in_valid && !accepted_all)) begin
        in_valid = $urandom_range(0, 3) != 0;
        if (in_valid) begin
          in_data  = next_val;
          next_val = next_val + 16'd1;
        end else begin
          in_data = 16'($urandom);
        end
      end
      cycle(1);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) cycle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
